// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the core datapath and a req/gnt/rvalid data bus.
//   Takes one access at a time. The core stays stalled until the access completes.
//   Store data and byte enables are steered onto the byte lanes. Load data is
//   shifted down and then sign- or zero-extended.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge) and asynchronous active-low reset
//   i_memwrite        store request from the decoder
//   i_memread         load request from the decoder
//   i_f3              access size and sign from the decoder
//   i_addr, i_wdata   ALU byte address and rs2 store data
//   o_stall           holds PC and regfile write while high
//   o_rdata           extended load result, valid in the DONE cycle
//   o_fault           1-cycle pulse in DONE: misaligned access or illegal f3
//   o_buserr          1-cycle pulse in DONE: the bus timed out
//   o_req, o_we       bus request and write enable
//   o_be, o_baddr     byte enables and word-aligned bus address
//   o_bwdata          lane-shifted store data
//   i_gnt             bus accepts the request
//   i_rvalid, i_bdata read data valid and read data word
module lsu_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_memwrite,
    input  logic            i_memread,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_fault,
    output logic            o_buserr,
    output logic            o_req,
    output logic            o_we,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_baddr,
    output logic [XLEN-1:0] o_bwdata,
    input  logic            i_gnt,
    input  logic            i_rvalid,
    input  logic [XLEN-1:0] i_bdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] baddr_q, baddr_d;
    logic [XLEN-1:0] bwdata_q, bwdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic            buserr_q, buserr_d;

    logic            access;
    logic            legal;
    logic            aligned;
    logic            accept;
    logic            timeout_hit;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] load_shift;
    logic [XLEN-1:0] load_ext;

    // Store wins when both requests are high.
    assign access = i_memread | i_memwrite;

    always_comb begin
        legal = 1'b0;
        if (i_memwrite) begin
            legal = (i_f3 == 3'b000) || (i_f3 == 3'b001) || (i_f3 == 3'b010);
        end else begin
            legal = (i_f3 == 3'b000) || (i_f3 == 3'b001) || (i_f3 == 3'b010) ||
                    (i_f3 == 3'b100) || (i_f3 == 3'b101);
        end
    end

    always_comb begin
        aligned = 1'b1;
        be_calc = 4'b1111;
        unique case (i_f3[1:0])
            2'b00: be_calc = 4'b0001 << i_addr[1:0];
            2'b01: begin
                aligned = ~i_addr[0];
                be_calc = 4'b0011 << i_addr[1:0];
            end
            default: aligned = (i_addr[1:0] == 2'b00);
        endcase
    end

    assign accept = legal & aligned;

    // A grant or rvalid that arrives in the last allowed cycle still completes normally.
    // The >= comparison also catches a load granted in that last cycle.
    assign timeout_hit = (cnt_q >= 8'(TIMEOUT - 1));

    assign load_shift = i_bdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = load_shift;
        unique case (f3_q)
            3'b000:  load_ext = {{(XLEN-8){load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{(XLEN-16){load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_shift[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            baddr_q  <= '0;
            bwdata_q <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            cnt_q    <= 8'd0;
            fault_q  <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            be_q     <= be_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            buserr_q <= buserr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    state_d = accept ? StReq : StDone;
                end
            end
            StReq: begin
                if (i_gnt) begin
                    state_d = we_q ? StDone : StWait;
                end else if (timeout_hit) begin
                    state_d = StDone;
                end
            end
            StWait: begin
                if (i_rvalid || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values
    always_comb begin
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        be_d     = be_q;
        f3_d     = f3_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        fault_d  = 1'b0;
        buserr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (access) begin
                    if (accept) begin
                        baddr_d  = {i_addr[XLEN-1:2], 2'b00};
                        bwdata_d = i_wdata << {i_addr[1:0], 3'b000};
                        we_d     = i_memwrite;
                        be_d     = be_calc;
                        f3_d     = i_f3;
                        off_d    = i_addr[1:0];
                    end else begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                if (!i_gnt && timeout_hit) begin
                    buserr_d = 1'b1;
                    rdata_d  = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (i_rvalid) begin
                    rdata_d = load_ext;
                end else if (timeout_hit) begin
                    buserr_d = 1'b1;
                    rdata_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        o_stall  = 1'b1;
        o_req    = 1'b0;
        o_we     = 1'b0;
        o_be     = 4'b0000;
        unique case (state_q)
            StIdle: o_stall = access;
            StReq: begin
                o_req = 1'b1;
                o_we  = we_q;
                o_be  = be_q;
            end
            StDone:  o_stall = 1'b0;
            default: o_stall = 1'b1;
        endcase
        o_baddr  = baddr_q;
        o_bwdata = bwdata_q;
        o_rdata  = rdata_q;
        o_fault  = fault_q;
        o_buserr = buserr_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int TO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_memwrite = 1'b0, i_memread = 1'b0;
    logic [2:0]  i_f3 = 3'b000;
    logic [31:0] i_addr = '0, i_wdata = '0, i_bdata = '0;
    logic        i_gnt = 1'b0, i_rvalid = 1'b0;
    logic        o_stall, o_fault, o_buserr, o_req, o_we;
    logic [31:0] o_rdata, o_baddr, o_bwdata;
    logic [3:0]  o_be;

    lsu_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_memwrite (i_memwrite),
        .i_memread  (i_memread),
        .i_f3       (i_f3),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_stall    (o_stall),
        .o_rdata    (o_rdata),
        .o_fault    (o_fault),
        .o_buserr   (o_buserr),
        .o_req      (o_req),
        .o_we       (o_we),
        .o_be       (o_be),
        .o_baddr    (o_baddr),
        .o_bwdata   (o_bwdata),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_bdata    (i_bdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        buserr;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          nerr = 0;
    int          nchk = 0;
    logic [31:0] last_rdata = '0;

    logic        obs_req, obs_stable, obs_done, obs_we, obs_fault, obs_buserr, obs_stall0;
    logic [3:0]  obs_be, obs_after;
    logic [31:0] obs_baddr, obs_bwdata, obs_rdata;
    int          obs_lat, obs_fault_n, obs_buserr_n;

    // Independent reference: byte-by-byte lane walk.
    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] bdata, input int gd, input int rvd,
                                   input bit rv_en, input logic [31:0] prev);
        exp_t        e;
        int          n;
        int          a;
        bit          ok;
        logic [31:0] v;
        a = int'(addr[1:0]);
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        if ((a % n) != 0) ok = 0;
        e.rdata = '0; e.fault = 1'b0; e.buserr = 1'b0; e.req = 1'b0; e.we = 1'b0;
        e.be = 4'b0000; e.baddr = addr & 32'hFFFF_FFFC; e.bwdata = '0; e.lat = 1;
        if (!ok) begin
            e.fault = 1'b1;
            return e;
        end
        e.req = 1'b1;
        e.we = st;
        for (int i = 0; i < 4; i++) begin
            if (i >= a && i < a + n) begin
                e.be[i] = 1'b1;
                e.bwdata[8*i +: 8] = wdata[8*(i-a) +: 8];
            end
        end
        if (st) begin
            e.rdata = prev;
            e.lat = 2 + gd;
        end else if (!rv_en) begin
            e.buserr = 1'b1;
            e.lat = 1 + TO;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = bdata[8*(a+i) +: 8];
            if (!f3[2] && n < 4 && v[8*n-1]) begin
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            e.rdata = v;
            e.lat = 3 + gd + rvd;
        end
        return e;
    endfunction

    // Drives one access and acts as the bus; records what the DUT did. Called at posedge+1.
    task automatic run_access(input logic st, input logic ld, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] bdata, input int gd, input int rvd,
                              input bit rv_en);
        int reqc = 0;
        int wc = 0;
        bit granted = 0;
        i_memwrite = st; i_memread = ld; i_f3 = f3; i_addr = addr; i_wdata = wdata;
        i_bdata = bdata;
        obs_req = 0; obs_stable = 1; obs_done = 0; obs_lat = -1;
        obs_fault_n = 0; obs_buserr_n = 0; obs_stall0 = 0;
        obs_be = '0; obs_baddr = '0; obs_bwdata = '0; obs_we = 0;
        obs_rdata = '0; obs_fault = 0; obs_buserr = 0;
        for (int cyc = 0; cyc < 64 && !obs_done; cyc++) begin
            @(negedge i_clk);
            i_gnt = 0; i_rvalid = 0; i_bdata = bdata;
            if (cyc == 0) obs_stall0 = o_stall;
            if (o_fault) obs_fault_n++;
            if (o_buserr) obs_buserr_n++;
            if (o_req) begin
                if (!obs_req) begin
                    obs_req = 1; obs_be = o_be; obs_baddr = o_baddr;
                    obs_bwdata = o_bwdata; obs_we = o_we;
                end else if (o_be !== obs_be || o_baddr !== obs_baddr ||
                             o_bwdata !== obs_bwdata || o_we !== obs_we) begin
                    obs_stable = 0;
                end
                reqc++;
                if (reqc > gd) begin
                    // rvalid alongside gnt carries poisoned data and must be ignored
                    i_gnt = 1; granted = 1; i_rvalid = 1; i_bdata = ~bdata;
                end
            end else if (granted && o_stall) begin
                if (rv_en && wc >= rvd) i_rvalid = 1;
                wc++;
            end
            if (!o_stall && cyc > 0) begin
                obs_done = 1; obs_lat = cyc; obs_rdata = o_rdata;
                obs_fault = o_fault; obs_buserr = o_buserr;
            end
        end
        i_memwrite = 0; i_memread = 0; i_gnt = 0; i_rvalid = 0;
        @(negedge i_clk);
        obs_after = {o_stall, o_req, o_fault, o_buserr};
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst_n = 0;
        @(negedge i_clk);
        nchk++;
        if ({o_stall, o_req, o_we, o_fault, o_buserr, o_be} !== 9'd0) begin
            nerr++; $display("FAIL reset_ctrl got=%b want=0",
                             {o_stall, o_req, o_we, o_fault, o_buserr, o_be});
        end
        nchk++;
        if ({o_rdata, o_baddr, o_bwdata} !== 96'd0) begin
            nerr++; $display("FAIL reset_data got=%h %h %h want=0", o_rdata, o_baddr, o_bwdata);
        end
        i_rst_n = 1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_store_word();
        exp_t e;
        sb.push_back(model(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, last_rdata));
        run_access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_be !== e.be || obs_bwdata !== e.bwdata || obs_we !== 1'b1) begin
            nerr++; $display("FAIL sw_bus got be=%b d=%h we=%b want be=%b d=%h we=1",
                             obs_be, obs_bwdata, obs_we, e.be, e.bwdata);
        end
        nchk++;
        if (obs_stall0 !== 1'b1 || obs_lat !== e.lat || obs_after !== 4'b0) begin
            nerr++; $display("FAIL sw_stall got stall0=%b lat=%0d after=%b want 1 %0d 0000",
                             obs_stall0, obs_lat, obs_after, e.lat);
        end
    endtask

    task automatic test_store_byte();
        exp_t e;
        sb.push_back(model(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 1, last_rdata));
        run_access(1, 0, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_be !== e.be || obs_bwdata[31:24] !== e.bwdata[31:24] ||
            obs_baddr !== e.baddr) begin
            nerr++; $display("FAIL sb_lane got be=%b d=%h a=%h want be=%b d=%h a=%h",
                             obs_be, obs_bwdata[31:24], obs_baddr, e.be, e.bwdata[31:24],
                             e.baddr);
        end
        nchk++;
        if (obs_lat !== e.lat || obs_rdata !== e.rdata) begin
            nerr++; $display("FAIL sb_done got lat=%0d rdata=%h want %0d %h",
                             obs_lat, obs_rdata, e.lat, e.rdata);
        end
    endtask

    task automatic test_load_sign();
        exp_t e;
        logic [2:0] f3s [2] = '{3'b000, 3'b100};
        for (int k = 0; k < 2; k++) begin
            sb.push_back(model(0, f3s[k], 32'h102, 32'h0, 32'h00800000, 0, 0, 1, last_rdata));
            run_access(0, 1, f3s[k], 32'h102, 32'h0, 32'h00800000, 0, 0, 1);
            e = sb.pop_front(); last_rdata = e.rdata;
            nchk++;
            if (obs_rdata !== e.rdata || obs_lat !== e.lat || obs_be !== e.be) begin
                nerr++; $display("FAIL load_ext f3=%b got rdata=%h lat=%0d be=%b want %h %0d %b",
                                 f3s[k], obs_rdata, obs_lat, obs_be, e.rdata, e.lat, e.be);
            end
        end
    endtask

    task automatic test_fault();
        exp_t e;
        // LH misaligned, then an illegal store size
        sb.push_back(model(0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1, last_rdata));
        run_access(0, 1, 3'b001, 32'h101, 32'h0, 32'h12345678, 0, 0, 1);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_fault_n !== 1 || obs_req !== e.req || obs_rdata !== e.rdata) begin
            nerr++; $display("FAIL lh_fault got pulses=%0d req=%b rdata=%h want 1 0 %h",
                             obs_fault_n, obs_req, obs_rdata, e.rdata);
        end
        nchk++;
        if (obs_lat !== e.lat || obs_after !== 4'b0) begin
            nerr++; $display("FAIL lh_release got lat=%0d after=%b want %0d 0000",
                             obs_lat, obs_after, e.lat);
        end
        sb.push_back(model(1, 3'b100, 32'h200, 32'h55, 32'h0, 0, 0, 1, last_rdata));
        run_access(1, 0, 3'b100, 32'h200, 32'h55, 32'h0, 0, 0, 1);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_fault !== e.fault || obs_req !== 1'b0 || obs_lat !== e.lat) begin
            nerr++; $display("FAIL st_f3_fault got fault=%b req=%b lat=%0d want 1 0 %0d",
                             obs_fault, obs_req, obs_lat, e.lat);
        end
    endtask

    task automatic test_delayed();
        exp_t e;
        sb.push_back(model(0, 3'b010, 32'h344, 32'h0, 32'hCAFEF00D, 3, 2, 1, last_rdata));
        run_access(0, 1, 3'b010, 32'h344, 32'h0, 32'hCAFEF00D, 3, 2, 1);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_stable !== 1'b1 || obs_be !== e.be || obs_baddr !== e.baddr) begin
            nerr++; $display("FAIL lw_hold got stable=%b be=%b a=%h want 1 %b %h",
                             obs_stable, obs_be, obs_baddr, e.be, e.baddr);
        end
        nchk++;
        if (obs_lat !== e.lat || obs_rdata !== e.rdata) begin
            nerr++; $display("FAIL lw_delay got lat=%0d rdata=%h want %0d %h",
                             obs_lat, obs_rdata, e.lat, e.rdata);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        sb.push_back(model(0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0, 0, 0, last_rdata));
        run_access(0, 1, 3'b010, 32'h400, 32'h0, 32'h11111111, 0, 0, 0);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_buserr !== 1'b1 || obs_buserr_n !== 1 || obs_rdata !== e.rdata) begin
            nerr++; $display("FAIL timeout got err=%b pulses=%0d rdata=%h want 1 1 %h",
                             obs_buserr, obs_buserr_n, obs_rdata, e.rdata);
        end
        nchk++;
        if (obs_lat !== e.lat || obs_after !== 4'b0) begin
            nerr++; $display("FAIL timeout_lat got lat=%0d after=%b want %0d 0000",
                             obs_lat, obs_after, e.lat);
        end
    endtask

    task automatic test_reset_midwait();
        exp_t e;
        i_memread = 1; i_f3 = 3'b010; i_addr = 32'h500;
        @(negedge i_clk);
        @(negedge i_clk);
        i_gnt = o_req;
        @(negedge i_clk);
        i_gnt = 0;
        repeat (3) @(negedge i_clk);
        #2;
        i_rst_n = 0; i_memread = 0;
        #1;
        nchk++;
        if ({o_stall, o_req, o_we, o_fault, o_buserr, o_be} !== 9'd0 ||
            {o_rdata, o_baddr, o_bwdata} !== 96'd0) begin
            nerr++; $display("FAIL rst_midwait got ctl=%b rdata=%h baddr=%h want all 0",
                             {o_stall, o_req, o_we, o_fault, o_buserr, o_be}, o_rdata, o_baddr);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        last_rdata = '0;
        @(posedge i_clk); #1;
        sb.push_back(model(1, 3'b001, 32'h602, 32'h0000BEEF, 32'h0, 0, 0, 1, last_rdata));
        run_access(1, 0, 3'b001, 32'h602, 32'h0000BEEF, 32'h0, 0, 0, 1);
        e = sb.pop_front(); last_rdata = e.rdata;
        nchk++;
        if (obs_lat !== e.lat || obs_be !== e.be || obs_bwdata[31:16] !== e.bwdata[31:16]) begin
            nerr++; $display("FAIL rst_recover got lat=%0d be=%b d=%h want %0d %b %h",
                             obs_lat, obs_be, obs_bwdata, e.lat, e.be, e.bwdata);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        st, ld;
        logic [2:0]  f3;
        logic [31:0] addr, wd, bd, m;
        int          gd, rvd;
        for (int k = 0; k < 40; k++) begin
            st = 1'($urandom_range(0, 1));
            ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom; wd = $urandom; bd = $urandom;
            gd = $urandom_range(0, 2); rvd = $urandom_range(0, 2);
            sb.push_back(model(st, f3, addr, wd, bd, gd, rvd, 1, last_rdata));
            run_access(st, ld, f3, addr, wd, bd, gd, rvd, 1);
            e = sb.pop_front(); last_rdata = e.rdata;
            nchk++;
            if (obs_lat !== e.lat || obs_rdata !== e.rdata) begin
                nerr++; $display("FAIL b2b_%0d_done got lat=%0d rdata=%h want %0d %h",
                                 k, obs_lat, obs_rdata, e.lat, e.rdata);
            end
            nchk++;
            if ({obs_fault, obs_buserr, obs_req} !== {e.fault, e.buserr, e.req}) begin
                nerr++; $display("FAIL b2b_%0d_flags got f/e/r=%b want %b", k,
                                 {obs_fault, obs_buserr, obs_req}, {e.fault, e.buserr, e.req});
            end
            if (e.req) begin
                m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                nchk++;
                if ({obs_we, obs_be, obs_baddr} !== {e.we, e.be, e.baddr} ||
                    (obs_bwdata & m) !== (e.bwdata & m)) begin
                    nerr++; $display("FAIL b2b_%0d_bus got we=%b be=%b a=%h d=%h want %b %b %h %h",
                                     k, obs_we, obs_be, obs_baddr, obs_bwdata & m,
                                     e.we, e.be, e.baddr, e.bwdata & m);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_sign();
        test_fault();
        test_delayed();
        test_timeout();
        test_reset_midwait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
